// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader: Q16.16 helpers,
// power-on operand banks, FSM states and error codes.
package operand_loader_pkg;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_EARLY   = 2'b01;
  localparam logic [1:0] ERR_MISSING = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Power-on contents of bank a: 1.0, 2.0, 3.0, ...
  function automatic logic [31:0] default_a(input int unsigned i);
    logic [31:0] v;
    v = 32'(i + 1);
    return v << 16;
  endfunction

  // Power-on contents of bank b: 7.0, 8.0, 9.0, ...
  function automatic logic [31:0] default_b(input int unsigned i);
    logic [31:0] v;
    v = 32'(i + 7);
    return v << 16;
  endfunction

endpackage

// File: rtl/loader_bank.sv
// One operand bank: an N-entry staging array filled word by word and an
// N-entry committed array that the chain reads. A commit copies the whole
// staging array at once, including a word being written on the same edge.
module loader_bank
  import operand_loader_pkg::*;
#(
  parameter int N    = 5,
  parameter int W    = 32,
  parameter bit IS_B = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
  input  logic [W-1:0]                      wdata,
  input  logic                              commit,
  output logic [N*W-1:0]                    flat
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      localparam logic [W-1:0] DEF = IS_B ? W'(default_b(gi)) : W'(default_a(gi));

      logic [W-1:0] stage_reg;
      logic [W-1:0] commit_reg;
      logic         hit;

      assign hit = we && (idx == IW'(gi));

      // Stage incoming words; on commit publish staging (bypassing the word landing now)
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg  <= '0;
          commit_reg <= DEF;
        end else begin
          if (hit) stage_reg <= wdata;
          if (commit) commit_reg <= hit ? wdata : stage_reg;
        end
      end

      assign flat[gi*W +: W] = commit_reg;
    end
  endgenerate

endmodule

// File: rtl/array_operand_loader.sv
// Serial-to-parallel operand feeder for the computation chain. Collects
// a[0..N-1] then b[0..N-1], commits both banks atomically, fires the chain
// and waits for its completion (or a timeout) before taking the next set.
module array_operand_loader
  import operand_loader_pkg::*;
#(
  parameter int N       = 5,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [N*W-1:0] array_a_flat,
  output logic [N*W-1:0] array_b_flat,
  output logic           start,
  input  logic           chain_valid,
  input  logic           chain_busy,
  output logic           valid,
  output logic           busy,
  output logic           err,
  output logic [1:0]     err_code
);

  localparam int CW = $clog2(2 * N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : TW'(0);
  localparam logic [CW-1:0] LAST_IDX = CW'(2 * N - 1);

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [TW-1:0]  tmo_reg;
  logic           valid_reg;
  logic           err_reg;
  logic [1:0]     err_code_reg;
  logic           settle_reg;
  logic [1:0]     rel_reg;

  logic           run;
  logic           accept;
  logic           last_word;
  logic           to_b;
  logic           commit;
  logic           timeout_hit;
  logic [IW-1:0]  idx_a;
  logic [IW-1:0]  idx_b;

  // Two-stage release: reset asserts immediately, deasserts after two edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rel_reg <= 2'b00;
    else        rel_reg <= {rel_reg[0], 1'b1};
  end

  assign run = rel_reg[1];

  // settle_reg keeps the port closed for the single cycle carrying valid/timeout err
  assign in_ready    = (state_reg == LOAD) && !settle_reg && (run || !reset);
  assign accept      = in_valid && (state_reg == LOAD) && !settle_reg && run;
  assign last_word   = (cnt_reg == LAST_IDX);
  assign to_b        = (cnt_reg >= CW'(N));
  assign commit      = accept && last_word && in_last;
  assign idx_a       = IW'(cnt_reg);
  assign idx_b       = IW'(cnt_reg - CW'(N));
  assign timeout_hit = (TIMEOUT != 0) && (tmo_reg >= TMO_LAST);

  // start is combinational so it can follow chain_busy falling in the same cycle
  assign start    = (state_reg == FIRE) && !chain_busy;
  assign busy     = (state_reg != LOAD) || (cnt_reg != '0);
  assign valid    = valid_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

  // Control FSM: word counting, commit, fire, completion/timeout tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= LOAD;
      cnt_reg      <= '0;
      tmo_reg      <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
      settle_reg   <= 1'b0;
    end else begin
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      settle_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (last_word) begin
              cnt_reg <= '0;
              if (in_last) begin
                state_reg <= FIRE;
              end else begin
                err_reg      <= 1'b1;
                err_code_reg <= ERR_MISSING;
              end
            end else if (in_last) begin
              cnt_reg      <= '0;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_EARLY;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        FIRE: begin
          if (!chain_busy) begin
            state_reg <= WAIT;
            // counts cycles since the start pulse, including the start cycle
            tmo_reg   <= TW'(1);
          end
        end
        WAIT: begin
          if (chain_valid) begin
            valid_reg  <= 1'b1;
            settle_reg <= 1'b1;
            state_reg  <= LOAD;
          end else if (timeout_hit) begin
            err_reg      <= 1'b1;
            err_code_reg <= ERR_TIMEOUT;
            settle_reg   <= 1'b1;
            state_reg    <= LOAD;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  loader_bank #(.N(N), .W(W), .IS_B(1'b0)) u_bank_a (
    .clk    (clk),
    .rst_n  (reset),
    .we     (accept && !to_b),
    .idx    (idx_a),
    .wdata  (in_data),
    .commit (commit),
    .flat   (array_a_flat)
  );

  loader_bank #(.N(N), .W(W), .IS_B(1'b1)) u_bank_b (
    .clk    (clk),
    .rst_n  (reset),
    .we     (accept && to_b),
    .idx    (idx_b),
    .wdata  (in_data),
    .commit (commit),
    .flat   (array_b_flat)
  );

endmodule

// File: tb/tb_array_operand_loader.sv
// Directed bench for array_operand_loader: error paths, nominal set,
// busy/timeout, asynchronous reset mid-operation and backpressured sets.
module tb_array_operand_loader;

  localparam int N       = 5;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;

  localparam logic [159:0] A_DEF = {32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
                                    32'h0002_0000, 32'h0001_0000};
  localparam logic [159:0] B_DEF = {32'h000B_0000, 32'h000A_0000, 32'h0009_0000,
                                    32'h0008_0000, 32'h0007_0000};

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] array_a_flat;
  logic [N*W-1:0] array_b_flat;
  logic           start;
  logic           chain_valid;
  logic           chain_busy;
  logic           valid;
  logic           busy;
  logic           err;
  logic [1:0]     err_code;

  int errors = 0;
  int checks = 0;

  logic [31:0] wa [5];
  logic [31:0] wb [5];

  always #5 clk = ~clk;

  array_operand_loader #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .array_a_flat (array_a_flat),
    .array_b_flat (array_b_flat),
    .start        (start),
    .chain_valid  (chain_valid),
    .chain_busy   (chain_busy),
    .valid        (valid),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {159'd0, obs}, {159'd0, exp});
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    chk(tag, {158'd0, obs}, {158'd0, exp});
  endtask

  function automatic logic [159:0] pack(input logic [31:0] x [5]);
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[i*32 +: 32] = x[i];
    return v;
  endfunction

  // Present one word after 'gap' idle cycles; returns at the negedge after the handshake
  task automatic send(input logic [31:0] d, input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk1("ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_set(input bit bp);
    for (int i = 0; i < 10; i++)
      send((i < 5) ? wa[i] : wb[i-5], (i == 9), bp ? int'($urandom_range(0, 2)) : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic saw_start;
    logic saw_valid;
    int   n;

    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    chain_valid = 1'b0; chain_busy = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_start", start, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk2("rst_err_code", err_code, 2'b00);
    chk("rst_a", array_a_flat, A_DEF);
    chk("rst_b", array_b_flat, B_DEF);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset state checked");

    // Early in_last on word 4
    for (int i = 0; i < 5; i++) send(32'hDEAD_0000 + 32'(i), (i == 4), 0);
    chk1("early_err", err, 1'b1);
    chk2("early_code", err_code, 2'b01);
    chk1("early_busy", busy, 1'b0);
    chk("early_a4", {128'd0, array_a_flat[159:128]}, {128'd0, 32'h0005_0000});
    saw_start = start;
    repeat (4) begin @(negedge clk); saw_start |= start; end
    chk1("early_nostart", saw_start, 1'b0);
    chk("early_a", array_a_flat, A_DEF);
    $display("early-last set: err_code=%b", err_code);

    // Missing in_last
    for (int i = 0; i < 10; i++) send(32'hBEEF_0000 + 32'(i), 1'b0, 0);
    chk1("miss_err", err, 1'b1);
    chk2("miss_code", err_code, 2'b10);
    saw_start = start;
    repeat (4) begin @(negedge clk); saw_start |= start; end
    chk1("miss_nostart", saw_start, 1'b0);
    chk("miss_a", array_a_flat, A_DEF);
    chk("miss_b", array_b_flat, B_DEF);
    $display("missing-last set: err_code=%b", err_code);

    // Nominal set, chain answers 3 cycles after start
    wa = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000};
    wb = '{32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000};
    send_set(1'b0);
    chk1("nom_start", start, 1'b1);
    chk1("nom_err", err, 1'b0);
    chk2("nom_code_held", err_code, 2'b10);
    chk("nom_a0", {128'd0, array_a_flat[31:0]}, {128'd0, 32'h0001_0000});
    chk("nom_b4", {128'd0, array_b_flat[159:128]}, {128'd0, 32'h0006_0000});
    chk("nom_b", array_b_flat, pack(wb));
    @(negedge clk);
    chk1("nom_start_pulse", start, 1'b0);
    chk1("nom_busy", busy, 1'b1);
    @(negedge clk);
    chain_valid = 1'b1;
    @(negedge clk);
    chain_valid = 1'b0;
    chk1("nom_valid", valid, 1'b1);
    chk1("nom_ready_hold", in_ready, 1'b0);
    @(negedge clk);
    chk1("nom_valid_pulse", valid, 1'b0);
    chk1("nom_ready_back", in_ready, 1'b1);
    chk1("nom_busy_clear", busy, 1'b0);
    $display("nominal set: b4=%h", array_b_flat[159:128]);

    // Chain busy for 20 cycles, then no chain_valid until timeout
    for (int i = 0; i < 5; i++) begin
      wa[i] = 32'h1234_0000 + 32'(i);
      wb[i] = 32'h8765_0000 + 32'(i);
    end
    chain_busy = 1'b1;
    send_set(1'b0);
    chk1("busy_hold_start", start, 1'b0);
    saw_start = 1'b0;
    saw_valid = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    chain_valid = 1'b1;
    repeat (20) begin @(negedge clk); saw_start |= start; saw_valid |= valid; end
    in_valid = 1'b0;
    chain_valid = 1'b0;
    chain_busy = 1'b0;
    #1;
    chk1("busy_start", start, 1'b1);
    chk1("busy_nostart", saw_start, 1'b0);
    chk1("busy_novalid", saw_valid, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 40);
    chk("tmo_cycles", 160'(n), 160'd16);
    chk2("tmo_code", err_code, 2'b11);
    chk1("tmo_ready_hold", in_ready, 1'b0);
    chk("tmo_a_kept", array_a_flat, pack(wa));
    @(negedge clk);
    chk1("tmo_ready_back", in_ready, 1'b1);
    chk1("tmo_err_pulse", err, 1'b0);
    chk1("tmo_busy", busy, 1'b0);
    $display("timeout: err after %0d cycles, code=%b", n, err_code);

    // Reset after word 6
    for (int i = 0; i < 6; i++) send(32'hC0DE_0000 + 32'(i), 1'b0, 0);
    chk1("mid_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", in_ready, 1'b1);
    chk2("mid_rst_code", err_code, 2'b00);
    chk("mid_rst_a", array_a_flat, A_DEF);
    chk("mid_rst_b", array_b_flat, B_DEF);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset mid-set checked");

    // Reset during WAIT, then a stray chain_valid
    for (int i = 0; i < 5; i++) begin
      wa[i] = 32'h0A0A_0000 + 32'(i);
      wb[i] = 32'h0B0B_0000 + 32'(i);
    end
    send_set(1'b0);
    chk1("wrst_start", start, 1'b1);
    chk("wrst_a", array_a_flat, pack(wa));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("wrst_busy", busy, 1'b0);
    chk("wrst_a_def", array_a_flat, A_DEF);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chain_valid = 1'b1;
    @(negedge clk);
    chain_valid = 1'b0;
    chk1("stray_valid", valid, 1'b0);
    chk1("stray_busy", busy, 1'b0);
    $display("reset in WAIT checked");

    // Three backpressured sets with random data
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 5; i++) begin
        wa[i] = $urandom;
        wb[i] = $urandom;
      end
      send_set(1'b1);
      chk1("bp_start", start, 1'b1);
      chk("bp_a", array_a_flat, pack(wa));
      chk("bp_b", array_b_flat, pack(wb));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      chain_valid = 1'b1;
      @(negedge clk);
      chain_valid = 1'b0;
      chk1("bp_valid", valid, 1'b1);
      @(negedge clk);
      chk1("bp_valid_pulse", valid, 1'b0);
      chk1("bp_ready", in_ready, 1'b1);
      $display("backpressure set %0d: a0=%h b4=%h", s, wa[0], wb[4]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
